// File: rtl/axi2i2c_pkg.sv
// Shared widths, AXI response codes and slave FSM states for the AXI-to-I2C bridge front end.
package axi2i2c_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned OADDR_W = 20;
  localparam int unsigned RDATA_W = 8;

  typedef enum logic [1:0] {
    Okay   = 2'b00,
    SlvErr = 2'b10,
    DecErr = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWCollect,
    StWReq,
    StWWait,
    StBResp,
    StRReq,
    StRWait,
    StRResp
  } slv_state_e;

endpackage

// File: rtl/axi_slave_if.sv
// AXI4-Lite channel bundle between an AXI master and the bridge slave front end.
interface axi_slave_if #(
  parameter int unsigned ADDR_W  = axi2i2c_pkg::ADDR_W,
  parameter int unsigned DATA_W  = axi2i2c_pkg::DATA_W,
  parameter int unsigned RESP_W  = axi2i2c_pkg::RESP_W,
  parameter int unsigned RDATA_W = axi2i2c_pkg::RDATA_W
);

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic              BVALID;
  logic              BREADY;
  logic [RESP_W-1:0] BRESP;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID;
  logic              RREADY;
  logic [RDATA_W-1:0] RDATA;
  logic [RESP_W-1:0] RRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi2i2c_slave_ctrl.sv
// AXI4-Lite slave front end: turns one AXI access at a time into a byte request to the I2C
// engine and the engine's completion into a B or R response. All outputs are registered.
module axi2i2c_slave_ctrl #(
  parameter int unsigned ADDR_W  = axi2i2c_pkg::ADDR_W,
  parameter int unsigned DATA_W  = axi2i2c_pkg::DATA_W,
  parameter int unsigned RESP_W  = axi2i2c_pkg::RESP_W,
  parameter int unsigned OADDR_W = axi2i2c_pkg::OADDR_W,
  parameter int unsigned RDATA_W = axi2i2c_pkg::RDATA_W
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_slave_if.slave         axi,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [OADDR_W-1:0] req_addr,
  output logic [RDATA_W-1:0] req_wdata,
  input  logic               rsp_valid,
  input  logic               rsp_nack,
  input  logic [RDATA_W-1:0] rsp_rdata
);
  import axi2i2c_pkg::*;

  function automatic logic is_decerr(logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OADDR_W] != '0;
  endfunction

  slv_state_e         state_q, state_d;
  logic               rr_q, rr_d;
  logic               aw_got_q, aw_got_d, w_got_q, w_got_d, ar_got_q, ar_got_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [RDATA_W-1:0] wbyte_q, wbyte_d;
  logic               awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic               bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  axi_resp_e          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [RDATA_W-1:0] rdata_q, rdata_d;
  logic               req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic [OADDR_W-1:0] req_addr_q, req_addr_d;
  logic [RDATA_W-1:0] req_wdata_q, req_wdata_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, req_hs;
  logic wr_go, rd_go;

  assign aw_hs  = axi.AWVALID & awready_q;
  assign w_hs   = axi.WVALID & wready_q;
  assign ar_hs  = axi.ARVALID & arready_q;
  assign b_hs   = bvalid_q & axi.BREADY;
  assign r_hs   = rvalid_q & axi.RREADY;
  assign req_hs = req_valid_q & req_ready;

  logic unused_wdata;
  assign unused_wdata = ^axi.WDATA[DATA_W-1:RDATA_W];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    aw_got_d    = aw_got_q | aw_hs;
    w_got_d     = w_got_q | w_hs;
    ar_got_d    = ar_got_q | ar_hs;
    awaddr_d    = aw_hs ? axi.AWADDR : awaddr_q;
    araddr_d    = ar_hs ? axi.ARADDR : araddr_q;
    wbyte_d     = w_hs ? axi.WDATA[RDATA_W-1:0] : wbyte_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    wr_go       = 1'b0;
    rd_go       = 1'b0;

    case (state_q)
      StIdle: begin
        // A contested cycle accepts both channels; the loser is parked and served next.
        if ((aw_hs | w_hs) && ar_hs) begin
          wr_go = ~rr_q;
          rd_go = rr_q;
          rr_d  = ~rr_q;
        end else begin
          wr_go = aw_hs | w_hs;
          rd_go = ar_hs;
        end
      end
      StWCollect: wr_go = 1'b1;
      StWReq: if (req_hs) state_d = StWWait;
      StWWait: begin
        if (rsp_valid) begin
          state_d = StBResp;
          bresp_d = rsp_nack ? SlvErr : Okay;
        end
      end
      StBResp: begin
        if (b_hs) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          if (ar_got_q) rd_go = 1'b1;
          else state_d = StIdle;
        end
      end
      StRReq: if (req_hs) state_d = StRWait;
      StRWait: begin
        if (rsp_valid) begin
          state_d = StRResp;
          rresp_d = rsp_nack ? SlvErr : Okay;
          rdata_d = rsp_nack ? '0 : rsp_rdata;
        end
      end
      StRResp: begin
        if (r_hs) begin
          ar_got_d = 1'b0;
          if (aw_got_q | w_got_q) wr_go = 1'b1;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_go) begin
      if (aw_got_d && w_got_d) begin
        if (is_decerr(awaddr_d)) begin
          state_d = StBResp;
          bresp_d = DecErr;
        end else begin
          state_d     = StWReq;
          req_write_d = 1'b1;
          req_addr_d  = awaddr_d[OADDR_W-1:0];
          req_wdata_d = wbyte_d;
        end
      end else begin
        state_d = StWCollect;
      end
    end else if (rd_go) begin
      if (is_decerr(araddr_d)) begin
        state_d = StRResp;
        rresp_d = DecErr;
        rdata_d = '0;
      end else begin
        state_d     = StRReq;
        req_write_d = 1'b0;
        req_addr_d  = araddr_d[OADDR_W-1:0];
      end
    end

    // Output flops are loaded from the next state so every output is a plain register.
    awready_d   = (state_d == StIdle) || ((state_d == StWCollect) && !aw_got_d);
    wready_d    = (state_d == StIdle) || ((state_d == StWCollect) && !w_got_d);
    arready_d   = (state_d == StIdle);
    bvalid_d    = (state_d == StBResp);
    rvalid_d    = (state_d == StRResp);
    req_valid_d = (state_d == StWReq) || (state_d == StRReq);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      ar_got_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wbyte_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= Okay;
      rresp_q     <= Okay;
      rdata_q     <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      ar_got_q    <= ar_got_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wbyte_q     <= wbyte_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.ARREADY = arready_q;
  assign axi.BVALID  = bvalid_q;
  assign axi.BRESP   = RESP_W'(bresp_q);
  assign axi.RVALID  = rvalid_q;
  assign axi.RRESP   = RESP_W'(rresp_q);
  assign axi.RDATA   = rdata_q;
  assign req_valid   = req_valid_q;
  assign req_write   = req_write_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;

endmodule

// File: tb/tb_axi2i2c_slave_ctrl.sv
// Directed bench for axi2i2c_slave_ctrl: a hand-driven AXI master and I2C engine.
module tb_axi2i2c_slave_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_rdata;

  int errors = 0;
  int checks = 0;

  axi_slave_if ax ();

  axi2i2c_slave_ctrl dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .axi       (ax),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .rsp_rdata (rsp_rdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Engine accepts the pending request, then completes it on the following edge.
  task automatic eng(input logic nack, input logic [7:0] data);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("req_drop", req_valid, 0);
    rsp_valid = 1'b1;
    rsp_nack  = nack;
    rsp_rdata = data;
    step();
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
  endtask

  task automatic b_take(input logic [1:0] resp);
    chk("bvalid", ax.BVALID, 1);
    chk("bresp", ax.BRESP, resp);
    ax.BREADY = 1'b1;
    step();
    ax.BREADY = 1'b0;
    chk("bvalid_clr", ax.BVALID, 0);
  endtask

  task automatic r_take(input logic [1:0] resp, input logic [7:0] data);
    chk("rvalid", ax.RVALID, 1);
    chk("rresp", ax.RRESP, resp);
    chk("rdata", ax.RDATA, data);
    ax.RREADY = 1'b1;
    step();
    ax.RREADY = 1'b0;
    chk("rvalid_clr", ax.RVALID, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ax.AWVALID = 0; ax.AWADDR = 0; ax.WVALID = 0; ax.WDATA = 0; ax.BREADY = 0;
    ax.ARVALID = 0; ax.ARADDR = 0; ax.RREADY = 0;
    req_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;

    // Reset state
    step(); step();
    chk("rst_ready", {ax.AWREADY, ax.WREADY, ax.ARREADY}, 0);
    chk("rst_valid", {ax.BVALID, ax.RVALID, req_valid}, 0);
    chk("rst_resp", {ax.BRESP, ax.RRESP, ax.RDATA}, 0);
    ARESETn = 1'b1;
    step();
    chk("idle_ready", {ax.AWREADY, ax.WREADY, ax.ARREADY}, 3'b111);

    // Write with AW and W together; WDATA upper bits ignored
    ax.AWVALID = 1; ax.AWADDR = 32'h0000_0123; ax.WVALID = 1; ax.WDATA = 32'hDEAD_BEA5;
    step();
    ax.AWVALID = 0; ax.WVALID = 0;
    chk("w1_req_valid", req_valid, 1);
    chk("w1_req_write", req_write, 1);
    chk("w1_req_addr", req_addr, 32'h123);
    chk("w1_req_wdata", req_wdata, 32'hA5);
    chk("w1_ready_low", {ax.AWREADY, ax.WREADY, ax.ARREADY}, 0);
    step();
    chk("w1_req_hold", {req_valid, req_addr}, {1'b1, 20'h00123});
    eng(1'b0, 8'h00);
    chk("w1_bvalid", ax.BVALID, 1);
    step();
    chk("w1_bvalid_hold", ax.BVALID, 1);
    b_take(2'b00);
    chk("w1_idle_ready", {ax.AWREADY, ax.WREADY, ax.ARREADY}, 3'b111);

    // W two cycles ahead of AW
    ax.WVALID = 1; ax.WDATA = 32'h0000_005A;
    step();
    ax.WVALID = 0;
    chk("w2_collect_ready", {ax.AWREADY, ax.WREADY, ax.ARREADY}, 3'b100);
    chk("w2_no_req", req_valid, 0);
    step();
    chk("w2_still_collect", {ax.AWREADY, ax.WREADY, req_valid}, 3'b100);
    ax.AWVALID = 1; ax.AWADDR = 32'h0000_0456;
    step();
    ax.AWVALID = 0;
    chk("w2_req", {req_valid, req_write, req_addr}, {1'b1, 1'b1, 20'h00456});
    chk("w2_wdata", req_wdata, 32'h5A);
    eng(1'b0, 8'h00);
    b_take(2'b00);

    // Read OK, then decode-error read, then read NACK
    ax.ARVALID = 1; ax.ARADDR = 32'h0000_0040;
    step();
    ax.ARVALID = 0;
    chk("r1_req", {req_valid, req_write, req_addr}, {1'b1, 1'b0, 20'h00040});
    eng(1'b0, 8'h3C);
    r_take(2'b00, 8'h3C);

    ax.ARVALID = 1; ax.ARADDR = 32'h0010_0000;
    step();
    ax.ARVALID = 0;
    chk("rdec_no_req", req_valid, 0);
    r_take(2'b11, 8'h00);

    ax.ARVALID = 1; ax.ARADDR = 32'h0000_0041;
    step();
    ax.ARVALID = 0;
    chk("r2_req_addr", req_addr, 32'h41);
    eng(1'b1, 8'h77);
    r_take(2'b10, 8'h00);

    // Decode-error write
    ax.AWVALID = 1; ax.AWADDR = 32'h0010_0000; ax.WVALID = 1; ax.WDATA = 32'h77;
    step();
    ax.AWVALID = 0; ax.WVALID = 0;
    chk("wdec_no_req", req_valid, 0);
    b_take(2'b11);

    // Simultaneous AR and write after a fresh reset: write first, then read first
    ARESETn = 0;
    step();
    ARESETn = 1;
    step();
    ax.AWVALID = 1; ax.AWADDR = 32'h10; ax.WVALID = 1; ax.WDATA = 32'h11;
    ax.ARVALID = 1; ax.ARADDR = 32'h20;
    step();
    ax.AWVALID = 0; ax.WVALID = 0; ax.ARVALID = 0;
    chk("arb1_first", {req_valid, req_write, req_addr}, {1'b1, 1'b1, 20'h00010});
    chk("arb1_wdata", req_wdata, 32'h11);
    eng(1'b0, 8'h00);
    b_take(2'b00);
    chk("arb1_second", {req_valid, req_write, req_addr}, {1'b1, 1'b0, 20'h00020});
    eng(1'b0, 8'h99);
    r_take(2'b00, 8'h99);
    chk("arb1_idle", {ax.AWREADY, ax.WREADY, ax.ARREADY, req_valid}, 4'b1110);

    ax.AWVALID = 1; ax.AWADDR = 32'h30; ax.WVALID = 1; ax.WDATA = 32'h31;
    ax.ARVALID = 1; ax.ARADDR = 32'h40;
    step();
    ax.AWVALID = 0; ax.WVALID = 0; ax.ARVALID = 0;
    chk("arb2_first", {req_valid, req_write, req_addr}, {1'b1, 1'b0, 20'h00040});
    eng(1'b0, 8'h42);
    r_take(2'b00, 8'h42);
    chk("arb2_second", {req_valid, req_write, req_addr}, {1'b1, 1'b1, 20'h00030});
    chk("arb2_wdata", req_wdata, 32'h31);
    eng(1'b1, 8'h00);
    b_take(2'b10);

    // Stalled request, then reset in WWAIT
    ax.AWVALID = 1; ax.AWADDR = 32'h55; ax.WVALID = 1; ax.WDATA = 32'h66;
    step();
    ax.AWVALID = 0; ax.WVALID = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {req_valid, req_write, req_addr, req_wdata}, {2'b11, 20'h00055, 8'h66});
      step();
    end
    req_ready = 1;
    step();
    req_ready = 0;
    chk("wwait_req_low", req_valid, 0);
    ARESETn = 0;
    #1;
    chk("mid_rst_outs", {ax.AWREADY, ax.WREADY, ax.ARREADY, ax.BVALID, ax.RVALID, req_valid}, 0);
    chk("mid_rst_req", {req_write, req_addr, req_wdata}, 0);
    step();
    ARESETn = 1;
    step();
    chk("post_rst_idle", {ax.AWREADY, ax.WREADY, ax.ARREADY, req_valid}, 4'b1110);
    rsp_valid = 1;
    step();
    rsp_valid = 0;
    chk("stray_rsp", {ax.BVALID, ax.RVALID, ax.AWREADY}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
